// File: rtl/mem_port_sched.sv
// Memory port scheduler: boot preload, then round-robin fetch/data sharing.
// Ports: clock/reset; boot_*; fetch_* and data_* requesters; mem_* port.
package mem_port_pkg;
  typedef enum logic [1:0] {
    write_byte = 2'd0,
    write_half = 2'd1,
    write_word = 2'd2
  } write_width_t;
endpackage

module mem_port_sched
  import mem_port_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INIT_BYTES = 36,
  parameter int BOOT_BASE  = 0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [XLEN-1:0]    boot_index,
  input  logic [7:0]         boot_byte,
  output logic               boot_done,
  input  logic               fetch_req,
  input  logic [XLEN-1:0]    fetch_addr,
  output logic               fetch_gnt,
  output logic               fetch_rvalid,
  output logic [XLEN-1:0]    fetch_rdata,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [XLEN-1:0]    data_addr,
  input  write_width_t       data_wwidth,
  input  logic [XLEN-1:0]    data_wdata,
  output logic               data_gnt,
  output logic               data_rvalid,
  output logic [XLEN-1:0]    data_rdata,
  output logic [XLEN-1:0]    mem_addr,
  output write_width_t       mem_wwidth,
  output logic               mem_wenable,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic [XLEN-1:0]    mem_rdata
);

  localparam logic [0:0] S_BOOT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic RR_FETCH = 1'b0;
  localparam logic RR_DATA  = 1'b1;

  localparam int LAST_I = (INIT_BYTES > 0) ? INIT_BYTES - 1 : 0;
  localparam logic [XLEN-1:0] LAST = XLEN'(LAST_I);
  localparam logic [XLEN-1:0] BASE = XLEN'(BOOT_BASE);
  localparam logic NO_BOOT = (INIT_BYTES == 0);

  logic [0:0]      state;
  logic [XLEN-1:0] count;
  logic            rr_last;
  logic            resp_f;
  logic            resp_d;
  logic [XLEN-1:0] f_hold;
  logic [XLEN-1:0] d_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= NO_BOOT ? S_RUN : S_BOOT;
      count     <= '0;
      boot_done <= NO_BOOT;
      rr_last   <= RR_DATA;
      resp_f    <= 1'b0;
      resp_d    <= 1'b0;
      f_hold    <= '0;
      d_hold    <= '0;
    end else begin
      resp_f <= fetch_gnt;
      resp_d <= data_gnt;
      if (resp_f) f_hold <= mem_rdata;
      if (resp_d) d_hold <= mem_rdata;
      if (state == S_BOOT) begin
        count <= count + 1'b1;
        if (count == LAST) begin
          state     <= S_RUN;
          boot_done <= 1'b1;
        end
      end
      if (fetch_gnt)
        rr_last <= RR_FETCH;
      else if (data_gnt)
        rr_last <= RR_DATA;
    end
  end

  always_comb begin
    fetch_gnt   = 1'b0;
    data_gnt    = 1'b0;
    boot_index  = '0;
    mem_addr    = '0;
    mem_wwidth  = write_word;
    mem_wenable = 1'b0;
    mem_wdata   = '0;
    if (!reset) begin
      unique case (1'b1)
        (state == S_BOOT): begin
          boot_index  = count;
          mem_wenable = 1'b1;
          mem_wwidth  = write_byte;
          mem_addr    = BASE + count;
          mem_wdata   = {{(XLEN-8){1'b0}}, boot_byte};
        end
        (state == S_RUN): begin
          // Fetch wins unless data is also asking and fetch won last.
          fetch_gnt = fetch_req &
                      (!data_req || rr_last == RR_DATA);
          data_gnt  = data_req & !fetch_gnt;
          if (fetch_gnt) begin
            mem_addr = fetch_addr;
          end else if (data_gnt) begin
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            if (data_we) begin
              mem_wenable = 1'b1;
              mem_wwidth  = data_wwidth;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Responses are dropped while reset is held.
  assign fetch_rvalid = resp_f & !reset;
  assign data_rvalid  = resp_d & !reset;
  assign fetch_rdata  = reset ? '0 :
                        (resp_f ? mem_rdata : f_hold);
  assign data_rdata   = reset ? '0 :
                        (resp_d ? mem_rdata : d_hold);

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: byte memory model, vector table and
// response scoreboard.
module tb_mem_port_sched;
  import mem_port_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  boot_index;
  logic [7:0]   boot_byte;
  logic         boot_done;
  logic         fetch_req;
  logic [31:0]  fetch_addr;
  logic         fetch_gnt;
  logic         fetch_rvalid;
  logic [31:0]  fetch_rdata;
  logic         data_req;
  logic         data_we;
  logic [31:0]  data_addr;
  write_width_t data_wwidth;
  logic [31:0]  data_wdata;
  logic         data_gnt;
  logic         data_rvalid;
  logic [31:0]  data_rdata;
  logic [31:0]  mem_addr;
  write_width_t mem_wwidth;
  logic         mem_wenable;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  mem_port_sched dut (
    .clock(clock), .reset(reset),
    .boot_index(boot_index), .boot_byte(boot_byte),
    .boot_done(boot_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wwidth(data_wwidth),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_addr(mem_addr), .mem_wwidth(mem_wwidth),
    .mem_wenable(mem_wenable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign boot_byte = boot_index[7:0] + 8'h10;

  logic [7:0] mem [256];
  logic [7:0] ma;
  always @(posedge clock) begin
    ma = mem_addr[7:0];
    if (mem_wenable) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_wwidth != write_byte)
        mem[ma+8'd1] <= mem_wdata[15:8];
      if (mem_wwidth == write_word) begin
        mem[ma+8'd2] <= mem_wdata[23:16];
        mem[ma+8'd3] <= mem_wdata[31:24];
      end
    end
    mem_rdata <= {mem[ma+8'd3], mem[ma+8'd2],
                  mem[ma+8'd1], mem[ma]};
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bb(input int i);
    return (i < 36) ? 8'(i + 16) : 8'h00;
  endfunction

  function automatic logic [31:0] bw(input logic [31:0] a);
    int i;
    i = int'(a);
    return {bb(i+3), bb(i+2), bb(i+1), bb(i)};
  endfunction

  typedef struct {
    bit          is_data;
    bit          chk_data;
    logic [31:0] val;
    int          due;
  } exp_t;
  exp_t q[$];

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rvalid_tag", {30'd0, fetch_rvalid, data_rvalid},
          e.is_data ? 32'd1 : 32'd2);
      if (e.chk_data)
        chk("rdata", e.is_data ? data_rdata : fetch_rdata, e.val);
    end else begin
      chk("no_rvalid", {30'd0, fetch_rvalid, data_rvalid}, 32'd0);
    end
  end

  typedef struct {
    bit          f;
    bit          d;
    logic [31:0] fa;
    logic [31:0] da;
    bit          gf;
    bit          gd;
  } vec_t;
  vec_t tv[11];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dreq(input bit we, input logic [31:0] a,
                      input write_width_t w,
                      input logic [31:0] wd,
                      input bit cd, input logic [31:0] ev);
    data_req    = 1'b1;
    data_we     = we;
    data_addr   = a;
    data_wwidth = w;
    data_wdata  = wd;
    @(negedge clock);
    chk("st_gnt", {30'd0, fetch_gnt, data_gnt}, 32'd1);
    chk("st_we", {31'd0, mem_wenable}, {31'd0, we});
    chk("st_width", {30'd0, mem_wwidth},
        {30'd0, we ? w : write_word});
    chk("st_addr", mem_addr, a);
    if (we) chk("st_wdata", mem_wdata, wd);
    q.push_back('{1'b1, cd, ev, cyc + 1});
    step();
  endtask

  initial begin
    tv[0]  = '{1, 0, 32'd0,  32'd0,  1, 0};
    tv[1]  = '{0, 1, 32'd0,  32'd4,  0, 1};
    tv[2]  = '{1, 1, 32'd8,  32'd12, 1, 0};
    tv[3]  = '{1, 1, 32'd16, 32'd20, 0, 1};
    tv[4]  = '{1, 1, 32'd24, 32'd28, 1, 0};
    tv[5]  = '{1, 1, 32'd32, 32'd0,  0, 1};
    tv[6]  = '{0, 0, 32'd4,  32'd8,  0, 0};
    tv[7]  = '{0, 1, 32'd0,  32'd8,  0, 1};
    tv[8]  = '{1, 1, 32'd4,  32'd12, 1, 0};
    tv[9]  = '{1, 0, 32'd8,  32'd0,  1, 0};
    tv[10] = '{1, 1, 32'd12, 32'd16, 0, 1};

    reset       = 1'b1;
    fetch_req   = 1'b1;
    fetch_addr  = 32'd0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    data_addr   = 32'd0;
    data_wwidth = write_word;
    data_wdata  = 32'd0;
    step();
    @(negedge clock);
    chk("rst_ctl",
        {28'd0, boot_done, fetch_gnt, data_gnt, mem_wenable},
        32'd0);
    chk("rst_rdata", fetch_rdata | data_rdata, 32'd0);
    step();
    reset = 1'b0;

    for (int k = 0; k < 36; k++) begin
      @(negedge clock);
      chk("boot_ctl",
          {26'd0, boot_done, fetch_gnt, data_gnt,
           mem_wenable, mem_wwidth},
          {26'd0, 1'b0, 1'b0, 1'b0, 1'b1, write_byte});
      chk("boot_idx", boot_index, k);
      chk("boot_addr", mem_addr, k);
      chk("boot_wdata", mem_wdata, 32'(k + 16));
      step();
    end

    for (int i = 0; i < 11; i++) begin
      fetch_req  = tv[i].f;
      data_req   = tv[i].d;
      fetch_addr = tv[i].fa;
      data_addr  = tv[i].da;
      data_we    = 1'b0;
      @(negedge clock);
      chk("tv_gnt", {30'd0, fetch_gnt, data_gnt},
          {30'd0, tv[i].gf, tv[i].gd});
      chk("tv_addr", mem_addr,
          tv[i].gf ? tv[i].fa : (tv[i].gd ? tv[i].da : 32'd0));
      chk("tv_ctl", {30'd0, boot_done, mem_wenable}, 32'd2);
      if (tv[i].gf) q.push_back('{1'b0, 1'b1, bw(tv[i].fa), cyc + 1});
      if (tv[i].gd) q.push_back('{1'b1, 1'b1, bw(tv[i].da), cyc + 1});
      step();
    end
    fetch_req = 1'b0;

    dreq(1'b1, 32'd64, write_word, 32'hDEADBEEF, 1'b0, 32'd0);
    dreq(1'b0, 32'd64, write_word, 32'd0, 1'b1, 32'hDEADBEEF);
    dreq(1'b1, 32'd65, write_byte, 32'h0000005A, 1'b0, 32'd0);
    dreq(1'b0, 32'd64, write_word, 32'd0, 1'b1, 32'hDEAD5AEF);
    data_req = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_ctl", {29'd0, fetch_gnt, data_gnt, mem_wenable},
          32'd0);
      chk("idle_addr", mem_addr, 32'd0);
      chk("hold_d", data_rdata, 32'hDEAD5AEF);
      chk("hold_f", fetch_rdata, 32'h1B1A1918);
      step();
    end

    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 32'd0;
    @(negedge clock);
    chk("mid_gnt", {30'd0, fetch_gnt, data_gnt}, 32'd1);
    step();
    data_req = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    chk("mid_rv", {31'd0, data_rvalid}, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("reboot_ctl",
          {28'd0, boot_done, data_rvalid, mem_wenable, data_gnt},
          32'd2);
      chk("reboot_addr", mem_addr, k);
      chk("reboot_idx", boot_index, k);
      step();
    end

    chk("sb_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
